// File: rtl/axi_rd_pkg.sv
// Shared types and AXI constants for the burst read master.
package axi_rd_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA,
      ST_DRAIN,
      ST_DONE
   } state_t;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

   // Bit positions inside err_code.
   localparam int unsigned ERR_RESP    = 0;
   localparam int unsigned ERR_RLAST   = 1;
   localparam int unsigned ERR_TIMEOUT = 2;

   // AXI size encoding: log2 of bytes per beat.
   function automatic logic [2:0] axi_size(input int unsigned data_w);
      return 3'($clog2(data_w / 8));
   endfunction

endpackage

// File: rtl/axi_rd_skid_buf.sv
// Two-entry registered valid/ready buffer carrying {last, data}.
module axi_rd_skid_buf
   import axi_rd_pkg::*;
#(
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              full,
   output logic              empty
);

   logic [DATA_W:0] mem [2];
   logic            wr_ptr;
   logic            rd_ptr;
   logic [1:0]      count;
   logic            push;
   logic            pop;

   assign full      = (count == 2'd2);
   assign empty     = (count == 2'd0);
   assign in_ready  = ~full;
   assign out_valid = ~empty;
   assign push      = in_valid & ~full;
   assign pop       = out_valid & out_ready;
   assign {out_last, out_data} = mem[rd_ptr];

   // Pointer and occupancy tracking; reset flushes the buffer.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end

   // Storage; contents are don't-care while empty.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {in_last, in_data};
   end

endmodule

// File: rtl/axi_burst_read_master.sv
// AXI4 INCR burst read master streaming beats out through a skid buffer.
module axi_burst_read_master
   import axi_rd_pkg::*;
#(
   parameter int unsigned ADDR_W  = 12,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned MAX_LEN = 16,
   parameter int unsigned TIMEOUT = 64,
   localparam int unsigned LEN_W  = $clog2(MAX_LEN + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [LEN_W-1:0]  req_len,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [2:0]        err_code,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] m_axi_araddr,
   output logic [7:0]        m_axi_arlen,
   output logic [2:0]        m_axi_arsize,
   output logic [1:0]        m_axi_arburst,
   output logic [3:0]        m_axi_arcache,
   output logic              m_axi_arlock,
   output logic [2:0]        m_axi_arprot,
   output logic              m_axi_arvalid,
   input  logic              m_axi_arready,
   input  logic [DATA_W-1:0] m_axi_rdata,
   input  logic [1:0]        m_axi_rresp,
   input  logic              m_axi_rlast,
   input  logic              m_axi_rvalid,
   output logic              m_axi_rready
);

   localparam int unsigned BYTES = DATA_W / 8;
   localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] addr_q;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  beat_cnt;
   logic [TMO_W-1:0]  tmo_cnt;
   logic [2:0]        err_q;
   logic              bad_req_q;

   logic [31:0]       addr_ext;
   logic [31:0]       end_off;
   logic              req_legal;
   logic              ar_hs;
   logic              r_hs;
   logic              beat_is_final;
   logic              burst_end;
   logic              tmo_hit;
   logic              sb_full;
   logic              sb_empty;
   logic              sb_in_ready;

   // Request legality: non-zero, within MAX_LEN, and inside one 4 KB page.
   always_comb begin
      addr_ext  = 32'(req_addr);
      end_off   = {20'b0, addr_ext[11:0]} + (32'(req_len) * BYTES);
      req_legal = (req_len != '0) && (32'(req_len) <= MAX_LEN) && (end_off <= 32'd4096);
   end

   assign ar_hs         = m_axi_arvalid & m_axi_arready;
   assign r_hs          = m_axi_rvalid & m_axi_rready;
   assign beat_is_final = (beat_cnt == len_q - LEN_W'(1));
   assign burst_end     = r_hs & (m_axi_rlast | beat_is_final);
   assign tmo_hit       = ((state == ST_ADDR) || (state == ST_DATA)) &&
                          (tmo_cnt == TMO_W'(TIMEOUT - 1)) && !(ar_hs || r_hs);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Next-state and control outputs.
   always_comb begin
      state_nxt     = state;
      busy          = 1'b0;
      done          = 1'b0;
      m_axi_arvalid = 1'b0;
      m_axi_rready  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) state_nxt = req_legal ? ST_ADDR : ST_DONE;
         end
         ST_ADDR: begin
            busy          = 1'b1;
            m_axi_arvalid = 1'b1;
            if (ar_hs)        state_nxt = ST_DATA;
            else if (tmo_hit) state_nxt = ST_DRAIN;
         end
         ST_DATA: begin
            busy         = 1'b1;
            m_axi_rready = sb_in_ready;
            if (burst_end || tmo_hit) state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            busy = 1'b1;
            if (sb_empty) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Request capture, beat/timeout counters and sticky error bits.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q    <= '0;
         len_q     <= '0;
         beat_cnt  <= '0;
         tmo_cnt   <= '0;
         err_q     <= '0;
         bad_req_q <= 1'b0;
      end else begin
         if ((state == ST_IDLE) && start) begin
            addr_q    <= req_addr;
            len_q     <= req_len;
            beat_cnt  <= '0;
            tmo_cnt   <= '0;
            err_q     <= '0;
            bad_req_q <= ~req_legal;
         end
         if ((state == ST_ADDR) || (state == ST_DATA)) begin
            if (ar_hs || r_hs) tmo_cnt <= '0;
            else               tmo_cnt <= tmo_cnt + TMO_W'(1);
            if (tmo_hit) err_q[ERR_TIMEOUT] <= 1'b1;
         end
         if (r_hs) begin
            beat_cnt <= beat_cnt + LEN_W'(1);
            if (m_axi_rresp != AXI_RESP_OKAY)   err_q[ERR_RESP]  <= 1'b1;
            if (m_axi_rlast != beat_is_final)   err_q[ERR_RLAST] <= 1'b1;
         end
      end
   end

   // AR channel fields are only driven while the address phase is active.
   always_comb begin
      m_axi_araddr  = '0;
      m_axi_arlen   = '0;
      m_axi_arsize  = '0;
      m_axi_arburst = '0;
      if (state == ST_ADDR) begin
         m_axi_araddr  = addr_q;
         m_axi_arlen   = 8'(len_q - LEN_W'(1));
         m_axi_arsize  = axi_size(DATA_W);
         m_axi_arburst = AXI_BURST_INCR;
      end
   end

   assign m_axi_arcache = '0;
   assign m_axi_arlock  = 1'b0;
   assign m_axi_arprot  = '0;

   assign err_code = err_q;
   assign err      = (state == ST_DONE) && (bad_req_q || (err_q != '0));

   axi_rd_skid_buf #(
      .DATA_W (DATA_W)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .in_data   (m_axi_rdata),
      .in_last   (m_axi_rlast | beat_is_final),
      .in_valid  (m_axi_rvalid & (state == ST_DATA)),
      .in_ready  (sb_in_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .full      (sb_full),
      .empty     (sb_empty)
   );

   logic unused_full;
   assign unused_full = sb_full;

endmodule

// File: tb/tb_axi_burst_read_master.sv
// Self-checking bench: directed plus random bursts against a transaction-level model.
module tb_axi_burst_read_master;

   localparam int ADDR_W  = 12;
   localparam int DATA_W  = 32;
   localparam int MAX_LEN = 16;
   localparam int TIMEOUT = 64;
   localparam int LEN_W   = 5;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [ADDR_W-1:0] req_addr;
   logic [LEN_W-1:0]  req_len;
   logic              busy, done, err;
   logic [2:0]        err_code;
   logic [DATA_W-1:0] out_data;
   logic              out_last, out_valid, out_ready;
   logic [ADDR_W-1:0] m_axi_araddr;
   logic [7:0]        m_axi_arlen;
   logic [2:0]        m_axi_arsize;
   logic [1:0]        m_axi_arburst;
   logic [3:0]        m_axi_arcache;
   logic              m_axi_arlock;
   logic [2:0]        m_axi_arprot;
   logic              m_axi_arvalid, m_axi_arready;
   logic [DATA_W-1:0] m_axi_rdata;
   logic [1:0]        m_axi_rresp;
   logic              m_axi_rlast, m_axi_rvalid, m_axi_rready;

   axi_burst_read_master #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .MAX_LEN (MAX_LEN),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .req_addr      (req_addr),
      .req_len       (req_len),
      .busy          (busy),
      .done          (done),
      .err           (err),
      .err_code      (err_code),
      .out_data      (out_data),
      .out_last      (out_last),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .m_axi_araddr  (m_axi_araddr),
      .m_axi_arlen   (m_axi_arlen),
      .m_axi_arsize  (m_axi_arsize),
      .m_axi_arburst (m_axi_arburst),
      .m_axi_arcache (m_axi_arcache),
      .m_axi_arlock  (m_axi_arlock),
      .m_axi_arprot  (m_axi_arprot),
      .m_axi_arvalid (m_axi_arvalid),
      .m_axi_arready (m_axi_arready),
      .m_axi_rdata   (m_axi_rdata),
      .m_axi_rresp   (m_axi_rresp),
      .m_axi_rlast   (m_axi_rlast),
      .m_axi_rvalid  (m_axi_rvalid),
      .m_axi_rready  (m_axi_rready)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Slave / consumer configuration for the current transaction
   int                cfg_ar_delay;
   bit                cfg_no_arready;
   int                cfg_nbeats;
   int                cfg_rlast_at;
   int                cfg_err_beat;
   int                cfg_rdy_mode;
   logic [DATA_W-1:0] sent [0:255];

   // Observed transaction state
   bit                ar_done;
   int                ar_wait;
   int                r_idx;
   int                occ;
   int                arv_cycles;
   int                rdy_phase;
   bit                done_seen;
   logic              got_err;
   logic [2:0]        got_code;
   logic [DATA_W:0]   got [$];
   logic [ADDR_W-1:0] exp_addr;
   int                exp_len;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_txn();
      ar_done = 0; ar_wait = 0; r_idx = 0; occ = 0; arv_cycles = 0; rdy_phase = 0;
      done_seen = 0; got_err = 1'bx; got_code = 'x; got.delete();
      m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
      m_axi_rresp = 2'b00; m_axi_rdata = '0; out_ready = 1'b0; start = 1'b0;
   endtask

   // One clock of slave, consumer and observation, all at the falling edge.
   task automatic cycle();
      @(negedge clk);
      start = 1'b0;
      if (done) begin
         done_seen = 1;
         got_err   = err;
         got_code  = err_code;
      end
      if (m_axi_arvalid) arv_cycles++;
      if (occ >= 2) check("rready_when_full", 64'(m_axi_rready), 64'(0));
      // R channel: present the next beat once the address has been accepted
      m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rresp = 2'b00;
      if (ar_done && r_idx < cfg_nbeats) begin
         m_axi_rvalid = 1'b1;
         m_axi_rdata  = sent[r_idx];
         m_axi_rresp  = (r_idx == cfg_err_beat) ? 2'b10 : 2'b00;
         m_axi_rlast  = (r_idx == cfg_rlast_at);
         if (m_axi_rready) begin
            r_idx++;
            occ++;
         end
      end
      // AR channel
      m_axi_arready = 1'b0;
      if (m_axi_arvalid && !ar_done) begin
         if (!cfg_no_arready && ar_wait >= cfg_ar_delay) begin
            m_axi_arready = 1'b1;
            ar_done = 1;
            check("araddr", 64'(m_axi_araddr), 64'(exp_addr));
            check("arlen", 64'(m_axi_arlen), 64'(exp_len - 1));
            check("arsize", 64'(m_axi_arsize), 64'(2));
            check("arburst", 64'(m_axi_arburst), 64'(1));
            check("ar_cache_lock_prot", 64'({m_axi_arcache, m_axi_arlock, m_axi_arprot}), 64'(0));
         end else begin
            ar_wait++;
         end
      end
      // Consumer
      case (cfg_rdy_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = ((rdy_phase % 3) == 0);
         2:       out_ready = 1'($urandom_range(0, 1));
         default: out_ready = 1'b0;
      endcase
      rdy_phase++;
      if (out_valid && out_ready) begin
         got.push_back({out_last, out_data});
         occ--;
      end
   endtask

   // Issue one request and compare the result with the transaction model.
   task automatic burst(input string tag, input int addr, input int len, input int ar_delay,
                        input int rlast_at, input int err_beat, input int rdy_mode,
                        input bit no_arready);
      bit   bad;
      int   n;
      logic [2:0] code;
      logic exp_err;
      logic [DATA_W:0] e;
      bad = (len == 0) || (len > MAX_LEN) || ((addr % 4096) + len * (DATA_W / 8) > 4096);
      n   = (rlast_at >= 0 && rlast_at < len) ? rlast_at + 1 : len;
      if (bad) begin
         n = 0; code = 3'b000; exp_err = 1'b1;
      end else if (no_arready) begin
         n = 0; code = 3'b100; exp_err = 1'b1;
      end else begin
         code = {1'b0, (rlast_at != len - 1), (err_beat >= 0 && err_beat < n)};
         exp_err = (code != 3'b000);
      end
      clear_txn();
      for (int i = 0; i < 256; i++) sent[i] = $urandom;
      cfg_ar_delay = ar_delay; cfg_no_arready = no_arready; cfg_nbeats = n;
      cfg_rlast_at = rlast_at; cfg_err_beat = err_beat; cfg_rdy_mode = rdy_mode;
      exp_addr = ADDR_W'(addr); exp_len = len;
      @(negedge clk);
      req_addr = ADDR_W'(addr);
      req_len  = LEN_W'(len);
      start    = 1'b1;
      for (int c = 0; c < 600 && !done_seen; c++) cycle();
      check({tag, "_done"}, 64'(done_seen), 64'(1));
      check({tag, "_err"}, 64'(got_err), 64'(exp_err));
      check({tag, "_code"}, 64'(got_code), 64'(code));
      check({tag, "_nbeats"}, 64'(got.size()), 64'(n));
      for (int i = 0; i < n && i < got.size(); i++) begin
         e = {(i == n - 1), sent[i]};
         check({tag, "_beat"}, 64'(got[i]), 64'(e));
      end
      if (bad) check({tag, "_no_arvalid"}, 64'(arv_cycles), 64'(0));
      if (no_arready && !bad)
         check({tag, "_arvalid_cycles"}, 64'(arv_cycles >= TIMEOUT && arv_cycles <= TIMEOUT + 1), 64'(1));
   endtask

   task automatic do_reset();
      clear_txn();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   function automatic logic [63:0] out_vec();
      return 64'({busy, done, err, err_code, out_valid, m_axi_arvalid, m_axi_rready,
                  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst});
   endfunction

   initial begin
      int len, addr, eb, rl;
      req_addr = '0; req_len = '0;
      do_reset();
      check("reset_outputs", out_vec(), 64'(0));

      // Basic burst, then backpressure pattern 1,0,0,...
      burst("basic", 'h100, 4, 2, 3, -1, 0, 0);
      burst("backpressure", 'h100, 4, 2, 3, -1, 1, 0);
      // SLVERR on beat 2 of 3
      burst("slverr", 'h200, 3, 0, 2, 1, 0, 0);
      // Early rlast, missing rlast
      burst("early_rlast", 'h300, 4, 1, 1, -1, 0, 0);
      burst("no_rlast", 'h400, 2, 0, -1, -1, 2, 0);
      // Illegal requests
      burst("len0", 'h100, 0, 0, -1, -1, 0, 0);
      burst("cross4k", 'hFF8, 4, 0, 3, -1, 0, 0);
      burst("too_long", 'h000, 17, 0, 16, -1, 0, 0);
      burst("max_len", 'hFC0, 16, 1, 15, -1, 1, 0);

      // Randomized legal/illegal mix
      for (int t = 0; t < 12; t++) begin
         len  = $urandom_range(1, MAX_LEN);
         addr = $urandom_range(0, 1023) * 4;
         eb   = ($urandom_range(0, 2) == 0) ? $urandom_range(0, len - 1) : -1;
         rl   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : len - 1;
         burst("random", addr, len, $urandom_range(0, 3), rl, eb, $urandom_range(0, 2), 0);
      end

      // Address-phase timeout; bus needs a reset afterwards
      burst("timeout", 'h500, 4, 0, 3, -1, 0, 1);
      do_reset();

      // Reset in the middle of the data phase
      clear_txn();
      for (int i = 0; i < 256; i++) sent[i] = $urandom;
      cfg_ar_delay = 0; cfg_no_arready = 0; cfg_nbeats = 8; cfg_rlast_at = 7;
      cfg_err_beat = -1; cfg_rdy_mode = 3; exp_addr = 'h600; exp_len = 8;
      @(negedge clk);
      req_addr = 'h600; req_len = 5'd8; start = 1'b1;
      for (int c = 0; c < 50 && r_idx < 2; c++) cycle();
      check("reached_data", 64'(r_idx >= 2), 64'(1));
      rst = 1'b1;
      @(negedge clk);
      check("mid_data_reset_outputs", out_vec(), 64'(0));
      rst = 1'b0;
      burst("after_reset", 'h700, 5, 1, 4, -1, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
